// File: rtl/ni_reg_loader.sv
// NI register loader: takes router flits, strips headers, buffers payload words and streams them
// into the NI register window. Optional build macro NI_PARITY_EN adds an even-parity check on flit_data.
module ni_reg_loader #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_WORDS = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flit_valid,
  output logic        flit_ready,
  input  logic [31:0] flit_data,
  input  logic [1:0]  flit_type,
`ifdef NI_PARITY_EN
  input  logic        flit_par,
`endif
  output logic        reg_en,
  output logic [31:0] wd_NI,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned CW = $clog2(MAX_WORDS + 1);

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic          r_live;
  logic [CW-1:0] r_cnt;

  // Each FIFO entry is {last, data}.
  logic [32:0]   r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [AW:0]   w_occ;
  logic [AW-1:0] w_newest;
  logic [32:0]   w_rd_ent;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;

  logic          r_reg_en;
  logic [31:0]   r_wd;
  logic          r_pkt_done;
  logic          r_pkt_err;

  logic          w_acc;
  logic          w_par_bad;
  logic          w_push;
  logic          w_push_last;
  logic          w_err;
  logic          w_done_hdr;
  logic          w_cnt_clr;
  logic          w_cnt_inc;
  logic          w_trunc;
  logic          w_trunc_pop;
  logic          w_trunc_mem;
  logic          w_trunc_gone;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop    = !w_empty;
  assign w_occ    = r_wptr - r_rptr;
  assign w_newest = r_wptr[AW-1:0] - AW'(1);
  assign w_rd_ent = r_mem[r_rptr[AW-1:0]];

  assign flit_ready = r_live && ((r_state != S_RECV) || !w_full || w_pop);
  assign w_acc      = flit_valid && flit_ready;

`ifdef NI_PARITY_EN
  assign w_par_bad = (flit_par != (^flit_data));
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_err       = 1'b0;
    w_done_hdr  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_trunc     = 1'b0;
    if (w_acc) begin
      case (r_state)
        S_IDLE: begin
          if (w_par_bad) begin
            w_err = 1'b1;
          end else begin
            case (flit_type)
              T_HEAD: begin
                w_state_nx = S_RECV;
                w_cnt_clr  = 1'b1;
              end
              T_HT:    w_done_hdr = 1'b1;
              default: w_err      = 1'b1;
            endcase
          end
        end
        S_RECV: begin
          if (w_par_bad) begin
            w_err      = 1'b1;
            w_state_nx = flit_type[1] ? S_IDLE : S_DROP;
          end else if ((flit_type == T_HEAD) || (flit_type == T_HT)) begin
            // A header mid-packet cuts the old packet short; its newest word becomes its last.
            w_err     = 1'b1;
            w_trunc   = (r_cnt != '0);
            w_cnt_clr = 1'b1;
            if (flit_type == T_HT) begin
              w_done_hdr = 1'b1;
              w_state_nx = S_IDLE;
            end
          end else if (r_cnt == CW'(MAX_WORDS)) begin
            w_err      = 1'b1;
            w_state_nx = (flit_type == T_TAIL) ? S_IDLE : S_DROP;
          end else begin
            w_push      = 1'b1;
            w_push_last = (flit_type == T_TAIL);
            w_cnt_inc   = 1'b1;
            if (flit_type == T_TAIL) begin
              w_state_nx = S_IDLE;
            end
          end
        end
        S_DROP: begin
          w_err = w_par_bad;
          if ((flit_type == T_TAIL) || (flit_type == T_HT)) begin
            w_state_nx = S_IDLE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // The newest word may be the one leaving this cycle, still queued behind others, or already written.
  assign w_trunc_pop  = w_trunc && (w_occ == (AW+1)'(1));
  assign w_trunc_mem  = w_trunc && (w_occ > (AW+1)'(1));
  assign w_trunc_gone = w_trunc && w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {w_push_last, flit_data};
    end
    if (w_trunc_mem) begin
      r_mem[w_newest][32] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_reg_en   <= 1'b0;
      r_wd       <= '0;
      r_pkt_done <= 1'b0;
      r_pkt_err  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
        r_wd   <= w_rd_ent[31:0];
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_reg_en   <= w_pop;
      r_pkt_done <= (w_pop && (w_rd_ent[32] || w_trunc_pop)) || w_done_hdr || w_trunc_gone;
      r_pkt_err  <= w_err;
    end
  end

  assign reg_en   = r_reg_en;
  assign wd_NI    = r_wd;
  assign pkt_done = r_pkt_done;
  assign pkt_err  = r_pkt_err;
  assign busy     = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_ni_reg_loader.sv
// Directed bench for ni_reg_loader; define NI_PARITY_EN to also cover the parity check.
module tb_ni_reg_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flit_valid = 1'b0;
  logic        flit_ready;
  logic [31:0] flit_data = '0;
  logic [1:0]  flit_type = '0;
`ifdef NI_PARITY_EN
  logic        flit_par = 1'b0;
`endif
  logic        reg_en;
  logic [31:0] wd_NI;
  logic        pkt_done;
  logic        pkt_err;
  logic        busy;

  ni_reg_loader #(.DEPTH(4), .MAX_WORDS(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .flit_data  (flit_data),
    .flit_type  (flit_type),
`ifdef NI_PARITY_EN
    .flit_par   (flit_par),
`endif
    .reg_en     (reg_en),
    .wd_NI      (wd_NI),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wlog[$];
  int          wcyc[$];
  int          ndone = 0;
  int          nerr = 0;
  int          done_cyc = 0;
  int          err_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_en) begin
        wlog.push_back(wd_NI);
        wcyc.push_back(cyc);
      end
      if (pkt_done) begin
        ndone = ndone + 1;
        done_cyc = cyc;
      end
      if (pkt_err) begin
        nerr = nerr + 1;
        err_cyc = cyc;
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int stalls = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_p(input logic [1:0] t, input logic [31:0] d, input logic p, output int acc);
    int w;
    w = 0;
    flit_valid = 1'b1;
    flit_type  = t;
    flit_data  = d;
`ifdef NI_PARITY_EN
    flit_par   = p;
`else
    if (p) w = 0;
`endif
    #1;
    while (!flit_ready && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    stalls += w;
    if (!flit_ready) chk("ready_timeout", {31'd0, flit_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    flit_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] t, input logic [31:0] d, output int acc);
    send_p(t, d, ^d, acc);
  endtask

  task automatic idle(input int n);
    flit_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int a, a1, a8, b, d0, e0;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_reg_en", {31'd0, reg_en}, 32'd0);
    chk("rst_wd_NI", wd_NI, 32'd0);
    chk("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    chk("rst_pkt_err", {31'd0, pkt_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, flit_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {31'd0, flit_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_edge", {31'd0, flit_ready}, 32'd1);

    // Basic packet: head, A1, A2, tail A3
    b = wlog.size(); d0 = ndone; e0 = nerr;
    send(2'b01, 32'hFFFF_0000, a);
    send(2'b00, 32'h0000_00A1, a1);
    send(2'b00, 32'h0000_00A2, a);
    send(2'b10, 32'h0000_00A3, a);
    idle(6);
    chk("basic_count", wlog.size() - b, 32'd3);
    chk("basic_w0", wlog[b], 32'hA1);
    chk("basic_w1", wlog[b+1], 32'hA2);
    chk("basic_w2", wlog[b+2], 32'hA3);
    chk("basic_lat0", wcyc[b], a1 + 1);
    chk("basic_lat2", wcyc[b+2], a1 + 3);
    chk("basic_done_cnt", ndone - d0, 32'd1);
    chk("basic_done_cyc", done_cyc, wcyc[b+2]);
    chk("basic_err_cnt", nerr - e0, 32'd0);
    chk("hold_wd", wd_NI, 32'hA3);
    chk("hold_reg_en", {31'd0, reg_en}, 32'd0);
    chk("basic_busy", {31'd0, busy}, 32'd0);

    // Overflow: 8 payload words then tail
    b = wlog.size(); d0 = ndone; e0 = nerr;
    send(2'b01, 32'h0, a);
    for (int i = 1; i <= 8; i++) begin
      send(2'b00, 32'h200 + i, a);
      if (i == 8) a8 = a;
    end
    chk("ovf_drop_busy", {31'd0, busy}, 32'd1);
    send(2'b10, 32'h209, a);
    idle(8);
    chk("ovf_count", wlog.size() - b, 32'd7);
    for (int i = 0; i < 7; i++) chk("ovf_word", wlog[b+i], 32'h201 + i);
    chk("ovf_err_cnt", nerr - e0, 32'd1);
    chk("ovf_err_cyc", err_cyc, a8);
    chk("ovf_done_cnt", ndone - d0, 32'd0);
    chk("ovf_busy", {31'd0, busy}, 32'd0);

    // Sustained traffic across pointer wrap
    b = wlog.size(); d0 = ndone; stalls = 0;
    for (int p = 0; p < 3; p++) begin
      send(2'b01, 32'h0, a);
      for (int k = 0; k < 6; k++) send(2'b00, 32'h100 + p*16 + k, a);
      send(2'b10, 32'h100 + p*16 + 6, a);
    end
    idle(6);
    chk("wrap_stalls", stalls, 32'd0);
    chk("wrap_count", wlog.size() - b, 32'd21);
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 7; k++) chk("wrap_word", wlog[b + p*7 + k], 32'h100 + p*16 + k);
    chk("wrap_done_cnt", ndone - d0, 32'd3);

    // Body in IDLE, then header-only packet
    b = wlog.size(); d0 = ndone; e0 = nerr;
    send(2'b00, 32'h55, a);
    send(2'b11, 32'h66, a);
    idle(4);
    chk("idle_err_cnt", nerr - e0, 32'd1);
    chk("idle_done_cnt", ndone - d0, 32'd1);
    chk("idle_err_then_done", done_cyc, err_cyc + 1);
    chk("idle_no_writes", wlog.size() - b, 32'd0);

    // Head mid-packet truncates
    b = wlog.size(); d0 = ndone; e0 = nerr;
    send(2'b01, 32'h0, a);
    send(2'b00, 32'hB1, a);
    send(2'b00, 32'hB2, a);
    send(2'b01, 32'h0, a);
    send(2'b00, 32'hC1, a);
    send(2'b10, 32'hC2, a);
    idle(6);
    chk("trunc_count", wlog.size() - b, 32'd4);
    chk("trunc_w1", wlog[b+1], 32'hB2);
    chk("trunc_w3", wlog[b+3], 32'hC2);
    chk("trunc_done_cnt", ndone - d0, 32'd2);
    chk("trunc_err_cnt", nerr - e0, 32'd1);

    // Reset mid-packet
    send(2'b01, 32'h0, a);
    send(2'b00, 32'hD1, a);
    send(2'b00, 32'hD2, a);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_reg_en", {31'd0, reg_en}, 32'd0);
    chk("mrst_wd_NI", wd_NI, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ready", {31'd0, flit_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b = wlog.size(); d0 = ndone; e0 = nerr;
    send(2'b01, 32'h0, a);
    send(2'b00, 32'hE1, a);
    send(2'b00, 32'hE2, a);
    send(2'b10, 32'hE3, a);
    idle(6);
    chk("mrst_count", wlog.size() - b, 32'd3);
    chk("mrst_w0", wlog[b], 32'hE1);
    chk("mrst_w2", wlog[b+2], 32'hE3);
    chk("mrst_done_cnt", ndone - d0, 32'd1);
    chk("mrst_err_cnt", nerr - e0, 32'd0);

`ifdef NI_PARITY_EN
    // Bad parity forces DROP until tail
    b = wlog.size(); d0 = ndone; e0 = nerr;
    send(2'b01, 32'h0, a);
    send(2'b00, 32'h10, a);
    send_p(2'b00, 32'h1, 1'b0, a);
    send(2'b00, 32'h2, a);
    send(2'b10, 32'h3, a);
    idle(6);
    chk("par_count", wlog.size() - b, 32'd1);
    chk("par_w0", wlog[b], 32'h10);
    chk("par_err_cnt", nerr - e0, 32'd1);
    chk("par_done_cnt", ndone - d0, 32'd0);
    chk("par_busy", {31'd0, busy}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
